// File: rtl/regex.sv
// Bit-serial Glushkov NFA matcher over {0,1}; one pattern position per state flop.
// Optional STICKY_MATCH_EN: o holds "matched anywhere since record start" until an i=0 edge.
module regex #(
  parameter int               N   = 4,
  parameter logic [2*N-1:0]   SYM = 8'b01010001,
  parameter logic [N-1:0]     REP = 4'b0010,
  parameter logic [N-1:0]     OPT = 4'b0000
) (
  input  logic clk,
  input  logic reset,
  input  logic i,
  input  logic i_c,
  output logic o
);

  logic [N-1:0] s_reg;
  logic [N-1:0] s_next;
  logic [N-1:0] carry;
  logic [N:0]   acc;

  // carry[k]: a token reaches position k, either injected or from an earlier
  // active position through a run of skippable positions.
  assign carry[0] = i;
  assign acc[0]   = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
      logic hit;
      assign hit        = SYM[2*gi+1] | (SYM[2*gi] == i_c);
      assign s_next[gi] = (carry[gi] | (REP[gi] & s_reg[gi])) & hit;
      // accept chain excludes the injected token so the empty string never matches
      assign acc[gi+1]  = s_reg[gi] | (OPT[gi] & acc[gi]);
      if (gi < N - 1) begin : g_carry
        assign carry[gi+1] = s_reg[gi] | (OPT[gi] & carry[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_reg <= '0;
    end else begin
      s_reg <= s_next;
    end
  end

`ifdef STICKY_MATCH_EN
  logic [N:0] nacc;
  logic       o_reg;

  assign nacc[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_nacc
      assign nacc[gi+1] = s_next[gi] | (OPT[gi] & nacc[gi]);
    end
  endgenerate

  // set wins over the end-of-record clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_reg <= 1'b0;
    end else if (nacc[N]) begin
      o_reg <= 1'b1;
    end else if (!i) begin
      o_reg <= 1'b0;
    end
  end

  assign o = o_reg;
`else
  assign o = acc[N];
`endif

endmodule

// File: tb/tb_regex.sv
// Directed scoreboard bench for regex with default pattern 1 0+ 1 1.
// Build with STICKY_MATCH_EN defined to exercise the sticky-match variant.
module tb_regex;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic i     = 1'b1;
  logic i_c   = 1'b0;
  logic o;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  regex dut (
    .clk   (clk),
    .reset (reset),
    .i     (i),
    .i_c   (i_c),
    .o     (o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic e;
    e = exp_q.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: o=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic c, input logic e);
    @(negedge clk);
    i   = st;
    i_c = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    $display("step %s i=%b c=%b o=%b exp=%b", tag, st, c, o, e);
    check(tag);
  endtask

  // bit vectors are listed first-bit-first (MSB of the n-bit field = first bit)
  task automatic seq(input string tag, input int n, input logic [31:0] bits,
                     input logic [31:0] starts, input logic [31:0] exps);
    for (int k = 0; k < n; k++) begin
      step(tag, starts[n-1-k], bits[n-1-k], exps[n-1-k]);
    end
  endtask

  // reset asserted between edges; o must drop before any clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(1'b0);
    #1;
    $display("reset %s o=%b exp=0", tag, o);
    check(tag);
    @(negedge clk);
    reset = 1'b1;
    i     = 1'b1;
  endtask

  initial begin
    exp_q.push_back(1'b0);
    #2;
    check("reset_state");
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 21; k++) begin
      step("idle", 1'b1, 1'b0, 1'b0);
    end

`ifdef STICKY_MATCH_EN
    do_reset("rst_sticky");
    seq("sticky", 6, 32'b101100, 32'hFFFF_FFFF, 32'b000111);
    step("sticky_clr", 1'b0, 1'b0, 1'b0);
    do_reset("rst_sticky_end");
`else
    seq("basic", 5, 32'b10110, 32'hFFFF_FFFF, 32'b00010);
    do_reset("rst_basic");
    seq("rep", 6, 32'b100011, 32'hFFFF_FFFF, 32'b000001);
    do_reset("rst_rep");
    seq("rep_nozero", 4, 32'b1111, 32'hFFFF_FFFF, 32'b0000);
    do_reset("rst_nozero");
    seq("overlap", 7, 32'b1011011, 32'hFFFF_FFFF, 32'b0001001);
    do_reset("rst_overlap_async");
    seq("anchor_miss", 5, 32'b01011, 32'b10000, 32'b00000);
    do_reset("rst_anchor");
    seq("anchor_hit", 4, 32'b1011, 32'b1000, 32'b0001);
    do_reset("rst_anchor_hit");
    seq("pre_reset", 3, 32'b101, 32'hFFFF_FFFF, 32'b000);
    do_reset("rst_midstream");
    step("post_reset", 1'b1, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: run did not complete, required completion");
    $fatal(1);
  end

endmodule
